// File: rtl/fall_timer_bank.sv
// Bank of independent fall timers.
// Each channel counts airborne cycles and latches a splat on a late landing.
module fall_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 6,
  parameter int THRESH = 20
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic [NUM_CH-1:0]       fall,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*CNT_W-1:0] cnt,
  output logic [NUM_CH-1:0]       over,
  output logic [NUM_CH-1:0]       splat,
  output logic                    any_splat
);

  if (NUM_CH < 1) begin : g_bad_ch
    $error("fall_timer_bank: NUM_CH must be >= 1");
  end

  if (THRESH < 1 || THRESH > (1 << CNT_W) - 1) begin : g_bad_th
    $error("fall_timer_bank: THRESH out of range 1..2^CNT_W-1");
  end

  typedef enum logic [1:0] {
    IDLE,
    FALLING,
    EXPIRED,
    SPLAT
  } st_t;

  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    st_t              st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n;

    // Saturating increment: the counter never wraps past all-ones.
    assign n = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (clr[g]) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else begin
        unique case (st_q)
          IDLE, FALLING: begin
            if (fall[g]) begin
              cnt_d = n;
              st_d  = (n >= TH) ? EXPIRED : FALLING;
            end else begin
              cnt_d = '0;
              st_d  = IDLE;
            end
          end
          EXPIRED: begin
            if (fall[g]) cnt_d = n;
            else         st_d  = SPLAT;
          end
          SPLAT: begin
            st_d  = SPLAT;
            cnt_d = cnt_q;
          end
          default: begin
            st_d  = IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      cnt[g*CNT_W +: CNT_W] = cnt_q;
      over[g]               = (st_q == EXPIRED);
      splat[g]              = (st_q == SPLAT);
    end
  end

  assign any_splat = |splat;

endmodule

// File: tb/tb_fall_timer_bank.sv
// Directed bench for fall_timer_bank.
// Covers default bank and a THRESH=1, CNT_W=2 corner instance.
module tb_fall_timer_bank;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  fall, clr;
  logic [23:0] cnt;
  logic [3:0]  over, splat;
  logic        any_splat;

  logic        fall1, clr1;
  logic [1:0]  cnt1;
  logic        over1, splat1, any1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fall_timer_bank u_dut (
    .clk       (clk),
    .areset    (areset),
    .fall      (fall),
    .clr       (clr),
    .cnt       (cnt),
    .over      (over),
    .splat     (splat),
    .any_splat (any_splat)
  );

  fall_timer_bank #(
    .NUM_CH (1),
    .CNT_W  (2),
    .THRESH (1)
  ) u_small (
    .clk       (clk),
    .areset    (areset),
    .fall      (fall1),
    .clr       (clr1),
    .cnt       (cnt1),
    .over      (over1),
    .splat     (splat1),
    .any_splat (any1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int c(input int i);
    logic [5:0] v;
    v = cnt[i*6 +: 6];
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    areset = 1'b1;
    fall   = '0;
    clr    = '0;
    fall1  = 1'b0;
    clr1   = 1'b0;
    #1;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_over", int'(over), 0);
    chk("rst_splat", int'(splat), 0);
    chk("rst_any", int'(any_splat), 0);
    chk("rst_small", int'({cnt1, over1, splat1}), 0);
    #3 areset = 1'b0;

    // 19-cycle fall lands safely
    fall[0] = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      chk("c0_rise", c(0), k);
      chk("c0_noover", int'(over[0]), 0);
    end
    fall[0] = 1'b0;
    step();
    chk("c0_land_cnt", c(0), 0);
    chk("c0_land_splat", int'(splat[0]), 0);

    // 20-cycle fall splats
    fall[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("c1_over", int'(over[1]), (k == 20) ? 1 : 0);
    end
    chk("c1_cnt20", c(1), 20);
    fall[1] = 1'b0;
    step();
    chk("c1_splat", int'(splat[1]), 1);
    chk("c1_any", int'(any_splat), 1);
    chk("c1_held", c(1), 20);
    chk("c1_over_off", int'(over[1]), 0);
    fall[1] = 1'b1;
    step();
    fall[1] = 1'b0;
    step();
    chk("c1_sticky", int'(splat[1]), 1);
    chk("c1_held2", c(1), 20);

    // saturation then clr overriding fall
    fall[2] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 64 || k == 70) begin
        chk("c2_sat", c(2), 63);
        chk("c2_over", int'(over[2]), 1);
      end
    end
    clr[2] = 1'b1;
    step();
    chk("c2_clr_cnt", c(2), 0);
    chk("c2_clr_over", int'(over[2]), 0);
    chk("c2_clr_splat", int'(splat[2]), 0);
    clr[2]  = 1'b0;
    fall[2] = 1'b0;

    // ch3 to SPLAT, ch0 mid-fall at 10, then async reset
    fall[3] = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      if (k == 21) fall[3] = 1'b0;
      fall[0] = (k >= 12);
      step();
    end
    chk("c3_splat", int'(splat[3]), 1);
    chk("c0_mid", c(0), 10);
    #2 areset = 1'b1;
    #1;
    chk("ar_cnt", int'(cnt), 0);
    chk("ar_over", int'(over), 0);
    chk("ar_splat", int'(splat), 0);
    chk("ar_any", int'(any_splat), 0);
    #1 areset = 1'b0;
    step();
    chk("ar_restart", c(0), 1);
    chk("ar_c3", c(3), 0);

    // same-cycle independent events
    fall[2] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 21) fall[2] = 1'b0;
      step();
    end
    chk("c0_25", c(0), 25);
    chk("c0_over25", int'(over[0]), 1);
    chk("c2_splat_b", int'(splat[2]), 1);
    fall[0] = 1'b0;
    fall[1] = 1'b1;
    clr[2]  = 1'b1;
    step();
    chk("mix_c0_splat", int'(splat[0]), 1);
    chk("mix_c0_cnt", c(0), 25);
    chk("mix_c1_cnt", c(1), 1);
    chk("mix_c1_over", int'(over[1]), 0);
    chk("mix_c1_splat", int'(splat[1]), 0);
    chk("mix_c2_cnt", c(2), 0);
    chk("mix_c2_splat", int'(splat[2]), 0);
    chk("mix_any", int'(any_splat), 1);
    fall = '0;
    clr  = '0;

    // THRESH=1, CNT_W=2 corner
    fall1 = 1'b1;
    step();
    chk("s_over", int'(over1), 1);
    chk("s_cnt1", int'(cnt1), 1);
    fall1 = 1'b0;
    step();
    chk("s_splat", int'(splat1), 1);
    chk("s_any", int'(any1), 1);
    clr1 = 1'b1;
    step();
    chk("s_clr", int'({cnt1, over1, splat1}), 0);
    clr1  = 1'b0;
    fall1 = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    chk("s_sat", int'(cnt1), 3);
    chk("s_sat_over", int'(over1), 1);
    fall1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
